// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction prefetch FIFO exposing head opcode and extended operand.
// Revision 1.0
`default_nettype none

module ir_queue #(
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       li,
  input  logic [INSTR_W-1:0]         i,
  input  logic                       nxt,
  input  logic                       ei,
  input  logic                       sx,
  output logic [OPC_W-1:0]           ctrl,
  output logic [DATA_W-1:0]          bus,
  output logic                       bus_oe,
  output logic                       ir_valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OPR_W = INSTR_W - OPC_W;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head;
  logic [OPR_W-1:0]   opr;
  logic [DATA_W-1:0]  ext;

  assign ir_valid = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  // A full queue still accepts a load when the head retires on the same edge.
  assign pop      = nxt & ir_valid;
  assign push     = li & (~full | nxt);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      if (push && !pop)      count <= CNT_W'(count + 1'b1);
      else if (pop && !push) count <= CNT_W'(count - 1'b1);
      if (li && full && !nxt) ovf <= 1'b1;
    end
  end

  // Storage is not reset; it is only observable through the ir_valid gating below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i;
  end

  assign head = mem[rd_ptr];
  assign opr  = head[OPR_W-1:0];

  always_comb begin
    ext = '0;
    ext[OPR_W-1:0] = opr;
    for (int b = OPR_W; b < DATA_W; b++) ext[b] = sx & opr[OPR_W-1];
  end

  assign ctrl   = ir_valid ? head[INSTR_W-1 -: OPC_W] : '0;
  assign bus_oe = ei & ir_valid;
  assign bus    = bus_oe ? ext : '0;

endmodule

`default_nettype wire

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: queue-based reference model, directed scenarios plus random traffic.
`default_nettype none

module tb_ir_queue;

  localparam int INSTR_W = 8;
  localparam int OPC_W   = 4;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int OPR_W   = INSTR_W - OPC_W;
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               clr = 1'b0;
  logic               li = 1'b0, nxt = 1'b0, ei = 1'b0, sx = 1'b0;
  logic [INSTR_W-1:0] i = '0;
  logic [OPC_W-1:0]   ctrl;
  logic [DATA_W-1:0]  bus;
  logic               bus_oe, ir_valid, full, ovf;
  logic [CNT_W-1:0]   count;

  ir_queue #(.INSTR_W(INSTR_W), .OPC_W(OPC_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .li(li), .i(i), .nxt(nxt), .ei(ei), .sx(sx),
    .ctrl(ctrl), .bus(bus), .bus_oe(bus_oe), .ir_valid(ir_valid),
    .full(full), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v; int ctrl; int bus; int oe; int cnt; int full; int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   model_q[$];
  int   model_ovf = 0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs derived from the queue contents with plain arithmetic.
  function automatic exp_t model_outputs(input int e, input int s);
    exp_t r;
    int head, opr, val;
    r.cnt  = model_q.size();
    r.v    = (r.cnt != 0);
    r.full = (r.cnt == DEPTH);
    r.ovf  = model_ovf;
    r.ctrl = 0; r.bus = 0; r.oe = 0;
    if (r.v) begin
      head   = model_q[0];
      r.ctrl = head / (2 ** OPR_W);
      opr    = head % (2 ** OPR_W);
      val    = (s && opr >= 2 ** (OPR_W-1)) ? opr - 2 ** OPR_W : opr;
      if (e) begin
        r.oe  = 1;
        r.bus = val & (2 ** DATA_W - 1);
      end
    end
    return r;
  endfunction

  // One clock period of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic cycle(input bit l, input int w, input bit n, input bit e, input bit s);
    bit was_full, do_pop, do_push;
    @(negedge clk);
    li = l; i = INSTR_W'(w); nxt = n; ei = e; sx = s;
    was_full = (model_q.size() == DEPTH);
    do_pop   = n && (model_q.size() != 0);
    do_push  = l && (!was_full || n);
    if (l && was_full && !n) model_ovf = 1;
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(w & (2 ** INSTR_W - 1));
    exp_q.push_back(model_outputs(e, s));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
    check({tag, "_valid"}, int'(ir_valid), 0);
    check({tag, "_bus"}, int'(bus), 0);
    check({tag, "_oe"}, int'(bus_oe), 0);
    check({tag, "_ctrl"}, int'(ctrl), 0);
    check({tag, "_full"}, int'(full), 0);
  endtask

  // Reset lands mid-period, away from any clock edge, and is checked before the next edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    li = 0; nxt = 0; ei = 1; sx = 1;
    #1 clr = 1'b0;
    #1 check_reset_state(tag);
    model_q.delete();
    model_ovf = 0;
    @(negedge clk);
    #1 clr = 1'b1;
  endtask

  // Monitor: one scoreboard entry per rising edge that had stimulus.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        check("sb_valid", int'(ir_valid), ex.v);
        check("sb_count", int'(count), ex.cnt);
        check("sb_full", int'(full), ex.full);
        check("sb_ovf", int'(ovf), ex.ovf);
        check("sb_ctrl", int'(ctrl), ex.ctrl);
        check("sb_bus", int'(bus), ex.bus);
        check("sb_oe", int'(bus_oe), ex.oe);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int popped[$];
    int pushed[$];
    #3 check_reset_state("por");
    #10 clr = 1'b1;

    // Reset then load
    do_reset("rst1");
    cycle(1, 'h55, 0, 1, 0);
    after_edge();
    check("load_valid", int'(ir_valid), 1);
    check("load_count", int'(count), 1);
    check("load_ctrl", int'(ctrl), 'h5);
    check("load_bus", int'(bus), 'h05);
    check("load_oe", int'(bus_oe), 1);

    // Sign extension of a negative operand
    do_reset("rst2");
    cycle(1, 'hF9, 0, 1, 1);
    after_edge();
    check("sx1_bus", int'(bus), 'hF9);
    sx = 0; #1;
    check("sx0_bus", int'(bus), 'h09);
    ei = 0; #1;
    check("ei0_bus", int'(bus), 'h00);
    check("ei0_oe", int'(bus_oe), 0);

    // Fill, overflow, then full push+pop and drain
    do_reset("rst3");
    cycle(1, 'h10, 0, 1, 0);
    cycle(1, 'h21, 0, 1, 0);
    cycle(1, 'h32, 0, 1, 0);
    cycle(1, 'h43, 0, 1, 0);
    after_edge();
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 4);
    cycle(1, 'h54, 0, 1, 0);
    after_edge();
    check("ovf_flag", int'(ovf), 1);
    check("ovf_count", int'(count), 4);
    check("ovf_ctrl", int'(ctrl), 'h1);
    cycle(1, 'h65, 1, 1, 0);
    after_edge();
    check("fpp_count", int'(count), 4);
    check("fpp_ctrl", int'(ctrl), 'h2);
    cycle(0, 0, 1, 1, 0); after_edge(); check("drain_ctrl1", int'(ctrl), 'h3);
    cycle(0, 0, 1, 1, 0); after_edge(); check("drain_ctrl2", int'(ctrl), 'h4);
    cycle(0, 0, 1, 1, 0); after_edge(); check("drain_ctrl3", int'(ctrl), 'h6);
    cycle(0, 0, 1, 1, 0); after_edge();
    check("drain_valid", int'(ir_valid), 0);
    check("drain_ctrl4", int'(ctrl), 0);
    check("ovf_sticky", int'(ovf), 1);

    // Empty advance, then alternating load/retire pairs across the pointer wrap
    do_reset("rst4");
    cycle(0, 0, 1, 1, 0);
    after_edge();
    check("empty_nxt_count", int'(count), 0);
    for (int k = 0; k < 6; k++) begin
      int w;
      w = $urandom_range(0, 255);
      pushed.push_back(w / 16);
      cycle(1, w, 0, 1, 1);
      after_edge();
      popped.push_back(int'(ctrl));
      cycle(0, 0, 1, 1, 1);
    end
    for (int k = 0; k < 6; k++) check("wrap_order", popped[k], pushed[k]);

    // Reset mid-operation with count=3 and ovf=1
    do_reset("rst5");
    for (int k = 0; k < 5; k++) cycle(1, 'h70 + k, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);
    after_edge();
    check("pre_rst_count", int'(count), 3);
    check("pre_rst_ovf", int'(ovf), 1);
    do_reset("rst_mid");

    // Random traffic against the model, with occasional resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rst_rand");
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 255),
            $urandom_range(0, 99) < 45, $urandom_range(0, 1), $urandom_range(0, 1));
    end
    cycle(0, 0, 0, 0, 0);
    after_edge();
    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ir_queue.md
IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 SHALL have parameter INSTR_W, default 8: instruction word width.
REQ-002 SHALL have parameter OPC_W, default 4: opcode field width, upper bits of the word; 1 <= OPC_W < INSTR_W.
REQ-003 SHALL have parameter DATA_W, default 8: operand output width; DATA_W >= INSTR_W-OPC_W.
REQ-004 SHALL have parameter DEPTH, default 4: prefetch queue entries; power of 2, >= 2.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port clr  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port li  input  1  load request: push i into the queue.
REQ-008 SHALL have port i  input  INSTR_W  instruction word to load.
REQ-009 SHALL have port nxt  input  1  advance: retire the current (head) instruction.
REQ-010 SHALL have port ei  input  1  enable the operand onto bus.
REQ-011 SHALL have port sx  input  1  operand mode: 1 = sign-extend, 0 = zero-extend.
REQ-012 SHALL have port ctrl  output  OPC_W  opcode of the head instruction.
REQ-013 SHALL have port bus  output  DATA_W  extended operand of the head instruction.
REQ-014 SHALL have port bus_oe  output  1  bus carries a valid operand.
REQ-015 SHALL have port ir_valid  output  1  the head entry holds an instruction.
REQ-016 SHALL have port full  output  1  queue holds DEPTH entries.
REQ-017 SHALL have port count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-018 SHALL have port ovf  output  1  sticky flag: a load was dropped.

Function
REQ-019 SHALL implement a circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-020 SHALL push i on a rising edge when li=1 and the queue is not full, or when li=1, nxt=1 and the queue is full.
REQ-021 SHALL pop the head on a rising edge when nxt=1 and ir_valid=1; nxt with an empty queue SHALL be ignored.
REQ-022 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 When the queue is empty and a load occurs, ir_valid, ctrl and bus SHALL reflect the new word immediately after that edge (1-cycle latency).
REQ-024 When li=1 while the queue is full and nxt=0, the word SHALL be dropped, queue contents SHALL be unchanged, and ovf SHALL be set on that edge; ovf SHALL clear only on reset.
REQ-025 ir_valid SHALL equal (count != 0); full SHALL equal (count == DEPTH).
REQ-026 ctrl SHALL equal head[INSTR_W-1 : INSTR_W-OPC_W] when ir_valid=1, else 0.
REQ-027 The operand SHALL be head[INSTR_W-OPC_W-1 : 0], extended to DATA_W with its MSB when sx=1 and with zeros when sx=0.
REQ-028 bus SHALL equal the extended operand when ei=1 and ir_valid=1, else 0; bus_oe SHALL equal ei AND ir_valid.
REQ-029 ctrl, bus and bus_oe SHALL be combinational from registered state, ei and sx; there SHALL be no tristate drivers.

Reset
REQ-030 While clr=0, count SHALL be 0, both pointers SHALL be 0, ovf SHALL be 0, and ctrl, bus, bus_oe, ir_valid and full SHALL be 0, regardless of clk.
REQ-031 Asserting clr mid-operation SHALL discard all queued entries immediately.
REQ-032 Storage contents need not be cleared by reset, but SHALL never be visible while ir_valid=0.

Verification (defaults INSTR_W=8, OPC_W=4, DATA_W=8, DEPTH=4)
REQ-033 Reset then load: clr pulse low; li=1, i=0x55 for 1 cycle -> next edge: ir_valid=1, count=1, ctrl=0x5; with ei=1, sx=0: bus=0x05, bus_oe=1.
REQ-034 Sign extension: head=0xF9, ei=1 -> sx=1 gives bus=0xF9, sx=0 gives bus=0x09; ei=0 gives bus=0x00, bus_oe=0.
REQ-035 Fill and overflow: load 0x10, 0x21, 0x32, 0x43 -> full=1, count=4. Then li=1, i=0x54, nxt=0 -> ovf=1, count=4, ctrl=0x1.
REQ-036 Full push and pop: from full with head 0x10, assert li=1, i=0x65, nxt=1 -> count=4, ctrl=0x2. Four further nxt pulses -> ctrl sequence 0x3, 0x4, 0x6, then ir_valid=0, ctrl=0.
REQ-037 Empty advance and wrap: nxt=1 on an empty queue -> count stays 0; then 6 alternating load/retire pairs -> pointers wrap and every popped ctrl matches the pushed opcode in order.
REQ-038 Reset mid-operation: with count=3 and ovf=1, drive clr=0 between clock edges -> count=0, ovf=0, ir_valid=0 and bus=0 immediately, without waiting for a clk edge.
